// File: rtl/nco_pkg.sv
// Shared constants and ROM content generation for the quadrature NCO.
package nco_pkg;

    localparam int  QUAD_W    = 2;
    localparam int  Q_MIR_BIT = 0;
    localparam int  Q_NEG_BIT = 1;
    localparam real PI        = 3.14159265358979323846;

    function automatic int phase_w(input int lut_aw);
        return lut_aw + QUAD_W;
    endfunction

    function automatic int quarter_turn(input int lut_aw);
        return 1 << lut_aw;
    endfunction

    // Half-step offset keeps the fold symmetric without a extra entry.
    function automatic int rom_entry(input int j, input int lut_aw, input int out_w);
        real ang;
        real amp;
        ang = (2.0 * j + 1.0) * PI / (2.0 ** (lut_aw + QUAD_W));
        amp = (2.0 ** (out_w - 1) - 1.0) * $sin(ang);
        return $rtoi(amp + 0.5);
    endfunction

endpackage

// File: rtl/nco_if.sv
// Control and sample bus of the quadrature NCO.
interface nco_if
    import nco_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
);
    localparam int P = phase_w(LUT_AW);

    logic                    en;
    logic [ACC_W-1:0]        ftw_in;
    logic                    ftw_load;
    logic [P-1:0]            phase_off;
    logic                    phase_clr;
    logic signed [OUT_W-1:0] sine;
    logic signed [OUT_W-1:0] cosine;
    logic                    out_valid;

    modport master (
        output en, ftw_in, ftw_load, phase_off, phase_clr,
        input  sine, cosine, out_valid
    );

    modport slave (
        input  en, ftw_in, ftw_load, phase_off, phase_clr,
        output sine, cosine, out_valid
    );

endinterface

// File: rtl/nco_qlut.sv
// Quarter-wave sine ROM with two registered read ports.
module nco_qlut
    import nco_pkg::*;
#(
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LUT_AW-1:0] addr_a_i,
    input  logic [LUT_AW-1:0] addr_b_i,
    output logic [OUT_W-1:0]  data_a_o,
    output logic [OUT_W-1:0]  data_b_o
);
    logic [OUT_W-1:0] rom [2**LUT_AW];
    logic [OUT_W-1:0] a_q, a_d, b_q, b_d;

    for (genvar j = 0; j < 2**LUT_AW; j++) begin : g_rom
        assign rom[j] = OUT_W'(rom_entry(j, LUT_AW, OUT_W));
    end

    always_comb begin
        a_d = rom[addr_a_i];
        b_d = rom[addr_b_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign data_a_o = a_q;
    assign data_b_o = b_q;

endmodule

// File: rtl/nco_quad.sv
// Quadrature NCO: FTW register, phase accumulator, fold, ROM, sign stage.
module nco_quad
    import nco_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 16
) (
    input logic  clk,
    input logic  rst,
    nco_if.slave bus
);
    localparam int P = phase_w(LUT_AW);
    localparam logic [P-1:0] QTR = P'(quarter_turn(LUT_AW));

    logic [ACC_W-1:0]        ftw_q, ftw_d, acc_q, acc_d, acc_eff;
    logic [P-1:0]            ps_q, ps_d, pc_q, pc_d;
    logic [LUT_AW:0]         fs_q, fs_d, fc_q, fc_d;
    logic                    ns3_q, nc3_q;
    logic [2:0]              vld_q, vld_d;
    logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic                    vo_q;
    logic [OUT_W-1:0]        rom_s, rom_c;

    // Returns {negate, rom address} for a full-circle phase.
    function automatic logic [LUT_AW:0] fold(input logic [P-1:0] p);
        logic [LUT_AW-1:0] i;
        i = p[LUT_AW-1:0];
        return {p[LUT_AW+Q_NEG_BIT], p[LUT_AW+Q_MIR_BIT] ? ~i : i};
    endfunction

    always_comb begin
        acc_eff = bus.phase_clr ? '0 : acc_q;
        acc_d   = acc_eff + (bus.en ? ftw_q : '0);
        ftw_d   = bus.ftw_load ? bus.ftw_in : ftw_q;
        ps_d    = ps_q;
        pc_d    = pc_q;
        if (bus.en) begin
            ps_d = acc_eff[ACC_W-1 -: P] + bus.phase_off;
            pc_d = acc_eff[ACC_W-1 -: P] + bus.phase_off + QTR;
        end
        fs_d  = fold(ps_q);
        fc_d  = fold(pc_q);
        vld_d = {vld_q[1:0], bus.en};
        sin_d = sin_q;
        cos_d = cos_q;
        if (vld_q[2]) begin
            sin_d = ns3_q ? -$signed(rom_s) : $signed(rom_s);
            cos_d = nc3_q ? -$signed(rom_c) : $signed(rom_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ftw_q <= '0;
            acc_q <= '0;
            ps_q  <= '0;
            pc_q  <= '0;
            fs_q  <= '0;
            fc_q  <= '0;
            ns3_q <= 1'b0;
            nc3_q <= 1'b0;
            vld_q <= '0;
            sin_q <= '0;
            cos_q <= '0;
            vo_q  <= 1'b0;
        end else begin
            ftw_q <= ftw_d;
            acc_q <= acc_d;
            ps_q  <= ps_d;
            pc_q  <= pc_d;
            fs_q  <= fs_d;
            fc_q  <= fc_d;
            ns3_q <= fs_q[LUT_AW];
            nc3_q <= fc_q[LUT_AW];
            vld_q <= vld_d;
            sin_q <= sin_d;
            cos_q <= cos_d;
            vo_q  <= vld_q[2];
        end
    end

    nco_qlut #(
        .LUT_AW(LUT_AW),
        .OUT_W (OUT_W)
    ) u_lut (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_a_i(fs_q[LUT_AW-1:0]),
        .addr_b_i(fc_q[LUT_AW-1:0]),
        .data_a_o(rom_s),
        .data_b_o(rom_c)
    );

    assign bus.sine      = sin_q;
    assign bus.cosine    = cos_q;
    assign bus.out_valid = vo_q;

endmodule

// File: tb/tb_nco_quad.sv
// Bench for nco_quad: directed and random steps against a trig reference model.
module tb_nco_quad;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nco_if #(.ACC_W(32), .LUT_AW(8), .OUT_W(16)) bus ();

    nco_quad #(.ACC_W(32), .LUT_AW(8), .OUT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    logic [31:0] m_acc = '0;
    logic [31:0] m_ftw = '0;
    int          exp_s [0:4095];
    int          exp_c [0:4095];
    bit          exp_v [0:4095];
    int          es = 0;
    int          ec = 0;
    bit          ev = 0;

    // Ideal sine at the centre of phase bin p of a 1024-step circle.
    function automatic int ref_val(input int p);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 *
                           (real'(p % 1024) + 0.5) / 1024.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit l,
                        input logic [31:0] f, input logic [9:0] o);
        logic [31:0] eff;
        int          p;
        rst           = r;
        bus.en        = e;
        bus.phase_clr = c;
        bus.ftw_load  = l;
        bus.ftw_in    = f;
        bus.phase_off = o;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_acc = '0;
            m_ftw = '0;
            for (int i = 0; i < 4; i++) exp_v[cyc+i] = 1'b0;
            es = 0;
            ec = 0;
        end else begin
            eff = c ? 32'd0 : m_acc;
            if (e) begin
                p = (int'(eff >> 22) + int'(o)) % 1024;
                exp_v[cyc+3] = 1'b1;
                exp_s[cyc+3] = ref_val(p);
                exp_c[cyc+3] = ref_val(p + 256);
            end
            m_acc = eff + (e ? m_ftw : 32'd0);
            if (l) m_ftw = f;
        end
        ev = exp_v[cyc];
        if (ev) begin
            es = exp_s[cyc];
            ec = exp_c[cyc];
        end
        #1;
        check("out_valid", int'(bus.out_valid), int'(ev));
        check("sine", int'(bus.sine), es);
        check("cosine", int'(bus.cosine), ec);
    endtask

    int stab [4] = '{101, 32767, -101, -32767};
    int ctab [4] = '{32767, -101, -32767, 101};
    logic [31:0] rf;

    initial begin
        for (int i = 0; i < 4096; i++) exp_v[i] = 1'b0;
        bus.en = 1'b1;
        bus.phase_clr = 1'b0;
        bus.ftw_load = 1'b0;
        bus.ftw_in = '0;
        bus.phase_off = '0;

        // reset with en high, then idle
        step(1, 1, 0, 0, 32'h0, 10'h0);
        check("rst_sine", int'(bus.sine), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 32'h0, 10'h0);

        // quarter-turn tone
        step(0, 0, 0, 1, 32'h4000_0000, 10'h0);
        step(0, 1, 1, 0, 32'h0, 10'h0);
        step(0, 1, 0, 0, 32'h0, 10'h0);
        step(0, 1, 0, 0, 32'h0, 10'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 32'h0, 10'h0);
            check("tone_sine", int'(bus.sine), stab[i%4]);
            check("tone_cos", int'(bus.cosine), ctab[i%4]);
            check("tone_valid", int'(bus.out_valid), 1);
        end

        // same tone, quarter-turn phase offset
        step(0, 1, 1, 0, 32'h0, 10'h100);
        step(0, 1, 0, 0, 32'h0, 10'h100);
        step(0, 1, 0, 0, 32'h0, 10'h100);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 32'h0, 10'h100);
            check("off_sine", int'(bus.sine), stab[(i+1)%4]);
        end

        // decrementing accumulator wraps through zero
        step(0, 1, 0, 1, 32'hFFFF_FFFF, 10'h0);
        step(0, 1, 1, 0, 32'h0, 10'h0);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 32'h0, 10'h0);

        // mid-stream load, then en gap
        step(0, 1, 0, 1, 32'h0123_4567, 10'h3);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 32'h0, 10'h3);
        step(0, 0, 0, 0, 32'h0, 10'h3);
        for (int i = 0; i < 5; i++) step(0, i == 1 || i == 2, 0, 0, 32'h0, 10'h3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rf = $urandom;
            step(($urandom % 64) == 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                 ($urandom % 8) == 0, rf, 10'($urandom));
        end

        // reset with three samples in flight
        step(0, 1, 0, 1, 32'h1357_9BDF, 10'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 10'h0);
        step(1, 1, 0, 0, 32'h0, 10'h0);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 32'h0, 10'h0);
            check("flush_valid", int'(bus.out_valid), 0);
        end
        // ftw cleared by reset: phase stays at the offset
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 32'h0, 10'h055);
        check("restart_sine", int'(bus.sine), ref_val(10'h055));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
